stage_sequencer: RTL and testbench
==================================

# stage_sequencer

Parametrised master sequencer for the digit-recognition datapath. It runs a clear-display phase, then waits for a user press. It then steps through NUM_STAGES slave units in a fixed order, each with its own start/done handshake. When the last stage completes, it latches that stage's result for the seven-segment display. Compared with the fixed two-stage controller, it adds:

- a generic stage count
- button edge detection
- result latching
- an optional per-stage watchdog with an error state

## Interface
Parameters:
- NUM_STAGES, 2, number of sequenced slave units, ≥1; stage 0 runs first.
- RESULT_W, 4, width of result and display code.
- BLANK_CODE, 10, display code when no result is shown (decimal point only).
- ERR_CODE, 14, display code in ERROR.
- TIMEOUT_CYCLES, 1048576, watchdog limit per stage (≥2; used only with SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; one clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  global enable; when 0, every register holds.
- button  in  1  user push button, level, already synchronised.
- painter_ready  in  1  graphics slave idle/clear complete.
- clear_display  out  1  request display clear.
- reset_display  out  1  graphics slave reset.
- enable_graphics  out  1  graphics slave enable.
- stage_start  out  NUM_STAGES  one-cycle start pulse, one-hot.
- stage_enable  out  NUM_STAGES  per-stage enable.
- stage_reset  out  NUM_STAGES  per-stage reset.
- stage_done  in  NUM_STAGES  per-stage completion level.
- result_in  in  RESULT_W  result of last stage, valid while stage_done[NUM_STAGES-1]=1.
- output_digit  out  RESULT_W  seven-segment code.
- busy  out  1  high in STAGE_START/STAGE_WAIT.
- error  out  1  high in ERROR.
- err_stage  out  max(1,clog2(NUM_STAGES))  index of the stage that timed out.

## Operation
- States: RESET, CLEAR_START, CLEAR_WAIT, IDLE, STAGE_START, STAGE_WAIT, DISPLAY, ERROR.
- Stage index register `idx` selects the active stage.
- Press detection: `press = button & ~button_q`, where `button_q` is a registered copy of button. A held button gives exactly one press.

State transitions (taken only when en=1):
- RESET→CLEAR_WAIT.
- CLEAR_START→CLEAR_WAIT.
- CLEAR_WAIT→IDLE when painter_ready=1.
- IDLE→STAGE_START on press; idx←0.
- STAGE_START→STAGE_WAIT; watchdog←0.
- STAGE_WAIT with stage_done[idx]=1:
  - if idx<NUM_STAGES-1: idx←idx+1, go to STAGE_START;
  - else: result_reg←result_in, go to DISPLAY.
- STAGE_WAIT with watchdog timeout (see Configuration): err_stage←idx, go to ERROR.
- DISPLAY→CLEAR_START on press.
- ERROR→CLEAR_START on press.
- Unused encodings→RESET.

Output decode (Moore, from state only):
- clear_display=1 in RESET and CLEAR_START.
- reset_display=1 in RESET only.
- enable_graphics=1 in CLEAR_START, CLEAR_WAIT and IDLE.
- stage_reset:
  - all ones in RESET, CLEAR_START, CLEAR_WAIT and ERROR;
  - otherwise all zeros.
- stage_enable:
  - all ones in IDLE;
  - one-hot(idx) in STAGE_START and STAGE_WAIT;
  - otherwise zero.
- stage_start=one-hot(idx) in STAGE_START only.
- output_digit:
  - result_reg in DISPLAY;
  - ERR_CODE in ERROR;
  - BLANK_CODE elsewhere.

Reset values:
- state=RESET, idx=0, result_reg=0, err_stage=0, button_q=0, watchdog=0.
- Hence clear_display=1, reset_display=1, stage_reset=all ones, all other outputs 0, output_digit=BLANK_CODE.

Boundary conditions:
- reset has priority over en and applies mid-sequence. In-flight stages are abandoned and force-reset on the next cycle.
- stage_done is ignored outside STAGE_WAIT. A done already high during STAGE_START is seen on the first STAGE_WAIT cycle.
- done and timeout in the same cycle: done wins.
- NUM_STAGES=1: idx is constant 0.

## Timing
- Press sampled at edge t (IDLE): STAGE_START is active during cycle t+1, giving a one-cycle stage_start.
- Done sampled at edge k in STAGE_WAIT:
  - the next stage's start is high during cycle k+1;
  - for the last stage, output_digit shows the result from cycle k+1.
- Minimum time per stage: 2 cycles (START plus one WAIT with done=1).
- en=0 freezes the state, idx, watchdog and button_q. Outputs stay constant.

## Configuration
- SEQ_TIMEOUT_EN defined:
  - watchdog counter clog2(TIMEOUT_CYCLES) bits, incrementing each en=1 cycle in STAGE_WAIT;
  - when the counter equals TIMEOUT_CYCLES-1 and done=0 at an edge, go to ERROR.
- SEQ_TIMEOUT_EN undefined:
  - no counter is built and ERROR is unreachable;
  - error=0 and err_stage=0 constantly;
  - the sequencer waits indefinitely.

## Test plan
- Reset, painter_ready=1 after 5 cycles → clear_display=1 at reset, IDLE reached; output_digit=10; stage_reset=all ones until IDLE.
- NUM_STAGES=3, button held 20 cycles, each done 3 cycles after its start, result_in=7 → exactly one start per stage, in order 0,1,2; output_digit=7 after last done; no restart while button held.
- DISPLAY, second press → CLEAR_START, clear_display pulse of 1 cycle, output_digit=10.
- SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, stage 1 never done → ERROR after 16 STAGE_WAIT cycles, error=1, err_stage=1, output_digit=14, stage_reset all ones; press → clear phase.
- en=0 for 10 cycles during STAGE_WAIT, done pulsed then dropped → state unchanged; done high again with en=1 → advance; then reset asserted mid-stage → RESET on next edge.

Source files
------------

// File: rtl/stage_sequencer_if.sv
// rtl/stage_sequencer_if.sv - start/done handshake bundle between the sequencer and its stage units
interface stage_sequencer_if #(
    parameter int NUM_STAGES = 2,
    parameter int RESULT_W   = 4
);
    logic [NUM_STAGES-1:0] stage_start;
    logic [NUM_STAGES-1:0] stage_enable;
    logic [NUM_STAGES-1:0] stage_reset;
    logic [NUM_STAGES-1:0] stage_done;
    logic [RESULT_W-1:0]   result_in;

    modport master (
        output stage_start,
        output stage_enable,
        output stage_reset,
        input  stage_done,
        input  result_in
    );

    modport slave (
        input  stage_start,
        input  stage_enable,
        input  stage_reset,
        output stage_done,
        output result_in
    );
endinterface

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - clear/press/stage-chain master sequencer; SEQ_TIMEOUT_EN adds a per-stage watchdog
module stage_sequencer #(
    parameter int NUM_STAGES     = 2,
    parameter int RESULT_W       = 4,
    parameter int BLANK_CODE     = 10,
    parameter int ERR_CODE       = 14,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int IDX_W          = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                button,
    input  logic                painter_ready,
    output logic                clear_display,
    output logic                reset_display,
    output logic                enable_graphics,
    stage_sequencer_if.master   stg,
    output logic [RESULT_W-1:0] output_digit,
    output logic                busy,
    output logic                error,
    output logic [IDX_W-1:0]    err_stage
);

    typedef enum logic [2:0] {
        S_RESET       = 3'd0,
        S_CLEAR_START = 3'd1,
        S_CLEAR_WAIT  = 3'd2,
        S_IDLE        = 3'd3,
        S_STAGE_START = 3'd4,
        S_STAGE_WAIT  = 3'd5,
        S_DISPLAY     = 3'd6,
        S_ERROR       = 3'd7
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic                button_q, button_d;
    logic                press;
    logic                timeout;
    logic [NUM_STAGES-1:0] idx_onehot;

`ifdef SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [IDX_W-1:0] err_stage_q, err_stage_d;

    assign timeout   = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign err_stage = err_stage_q;
`else
    assign timeout   = 1'b0;
    assign err_stage = '0;
`endif

    assign press      = button & ~button_q;
    assign idx_onehot = NUM_STAGES'(1) << idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_RESET;
            idx_q       <= '0;
            result_q    <= '0;
            button_q    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            wd_q        <= '0;
            err_stage_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            button_q    <= button_d;
`ifdef SEQ_TIMEOUT_EN
            wd_q        <= wd_d;
            err_stage_q <= err_stage_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        result_d    = result_q;
        button_d    = button_q;
`ifdef SEQ_TIMEOUT_EN
        wd_d        = wd_q;
        err_stage_d = err_stage_q;
`endif
        if (en) begin
            button_d = button;
            case (state_q)
                S_RESET:       state_d = S_CLEAR_WAIT;
                S_CLEAR_START: state_d = S_CLEAR_WAIT;
                S_CLEAR_WAIT:  if (painter_ready) state_d = S_IDLE;
                S_IDLE: begin
                    if (press) begin
                        state_d = S_STAGE_START;
                        idx_d   = '0;
                    end
                end
                S_STAGE_START: begin
                    state_d = S_STAGE_WAIT;
`ifdef SEQ_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end
                S_STAGE_WAIT: begin
`ifdef SEQ_TIMEOUT_EN
                    wd_d = wd_q + 1'b1;
`endif
                    // done is checked before the watchdog so a last-cycle completion still counts
                    if (stg.stage_done[idx_q]) begin
                        if (idx_q < LAST_IDX) begin
                            idx_d   = IDX_W'(idx_q + 1'b1);
                            state_d = S_STAGE_START;
                        end else begin
                            result_d = stg.result_in;
                            state_d  = S_DISPLAY;
                        end
                    end else if (timeout) begin
`ifdef SEQ_TIMEOUT_EN
                        err_stage_d = idx_q;
`endif
                        state_d = S_ERROR;
                    end
                end
                S_DISPLAY:     if (press) state_d = S_CLEAR_START;
                S_ERROR:       if (press) state_d = S_CLEAR_START;
                default:       state_d = S_RESET;
            endcase
        end
    end

    always_comb begin
        clear_display    = 1'b0;
        reset_display    = 1'b0;
        enable_graphics  = 1'b0;
        stg.stage_start  = '0;
        stg.stage_enable = '0;
        stg.stage_reset  = '0;
        output_digit     = RESULT_W'(BLANK_CODE);
        busy             = 1'b0;
        error            = 1'b0;
        case (state_q)
            S_RESET: begin
                clear_display   = 1'b1;
                reset_display   = 1'b1;
                stg.stage_reset = '1;
            end
            S_CLEAR_START: begin
                clear_display   = 1'b1;
                enable_graphics = 1'b1;
                stg.stage_reset = '1;
            end
            S_CLEAR_WAIT: begin
                enable_graphics = 1'b1;
                stg.stage_reset = '1;
            end
            S_IDLE: begin
                enable_graphics  = 1'b1;
                stg.stage_enable = '1;
            end
            S_STAGE_START: begin
                stg.stage_start  = idx_onehot;
                stg.stage_enable = idx_onehot;
                busy             = 1'b1;
            end
            S_STAGE_WAIT: begin
                stg.stage_enable = idx_onehot;
                busy             = 1'b1;
            end
            S_DISPLAY:     output_digit = result_q;
            S_ERROR: begin
                output_digit    = RESULT_W'(ERR_CODE);
                stg.stage_reset = '1;
                error           = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - scoreboard bench for stage_sequencer with three stages
module tb_stage_sequencer;
    localparam int NS = 3;
    localparam int RW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset, en, button, painter_ready;
    logic          clear_display, reset_display, enable_graphics, busy, error;
    logic [RW-1:0] output_digit;
    logic [1:0]    err_stage;

    stage_sequencer_if #(.NUM_STAGES(NS), .RESULT_W(RW)) stg ();

    stage_sequencer #(
        .NUM_STAGES(NS), .RESULT_W(RW), .BLANK_CODE(10), .ERR_CODE(14), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .button(button), .painter_ready(painter_ready),
        .clear_display(clear_display), .reset_display(reset_display),
        .enable_graphics(enable_graphics), .stg(stg), .output_digit(output_digit),
        .busy(busy), .error(error), .err_stage(err_stage)
    );

    always #5 clk = ~clk;

    // kind 0: stage_start vector, 1: new output_digit value, 2: err_stage on error entry
    typedef struct { int kind; int val; } ev_t;
    ev_t exp_q[$];
    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;
    logic [RW-1:0] prev_digit = 4'd10;
    logic          prev_err   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic take(input int kind, input logic [31:0] val);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event kind %0d: got %0d expected nothing", kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || val !== e.val) begin
                bad++;
                $display("FAIL event_order: got kind %0d value %0d expected kind %0d value %0d",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (stg.stage_start !== '0) take(0, 32'(stg.stage_start));
                if (output_digit !== prev_digit) take(1, 32'(output_digit));
                if (error === 1'b1 && prev_err !== 1'b1) take(2, 32'(err_stage));
            end
            prev_digit = output_digit;
            prev_err   = error;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press();
        button = 1'b1;
        tick(1);
        button = 1'b0;
    endtask

    task automatic wait_start(input int i);
        bit ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (stg.stage_start[i] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("start_seen_%0d", i), 32'(ok), 32'd1);
    endtask

    task automatic run_stage(input int i);
        wait_start(i);
        tick(3);
        stg.stage_done[i] = 1'b1;
        tick(1);
        stg.stage_done[i] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; en = 1'b1; button = 1'b0; painter_ready = 1'b0;
        stg.stage_done = '0; stg.result_in = '0;
        tick(2);
        mon_on = 1'b1;
        chk("rst_clear_display", 32'(clear_display), 1);
        chk("rst_reset_display", 32'(reset_display), 1);
        chk("rst_stage_reset", 32'(stg.stage_reset), 7);
        chk("rst_digit", 32'(output_digit), 10);
        chk("rst_start", 32'(stg.stage_start), 0);
        chk("rst_enable", 32'(stg.stage_enable), 0);
        chk("rst_busy_err_gfx", {29'd0, busy, error, enable_graphics}, 0);
        chk("rst_err_stage", 32'(err_stage), 0);

        reset = 1'b0;
        tick(1);
        chk("cw_clear_display", 32'(clear_display), 0);
        chk("cw_enable_graphics", 32'(enable_graphics), 1);
        tick(4);
        chk("cw_stage_reset", 32'(stg.stage_reset), 7);
        painter_ready = 1'b1;
        tick(1);
        chk("idle_stage_reset", 32'(stg.stage_reset), 0);
        chk("idle_stage_enable", 32'(stg.stage_enable), 7);

        stg.result_in = 4'd7;
        push(0, 1); push(0, 2); push(0, 4); push(1, 7);
        fork
            begin button = 1'b1; tick(20); button = 1'b0; end
            begin for (int i = 0; i < NS; i++) run_stage(i); end
        join
        chk("disp_digit", 32'(output_digit), 7);
        chk("disp_busy", 32'(busy), 0);
        chk("disp_stage_enable", 32'(stg.stage_enable), 0);
        tick(3);

        push(1, 10);
        button = 1'b1;
        tick(1);
        chk("cs_clear_display", 32'(clear_display), 1);
        button = 1'b0;
        tick(1);
        chk("cs_pulse_end", 32'(clear_display), 0);
        tick(1);
        chk("back_idle", 32'(stg.stage_enable), 7);

        push(0, 1); push(0, 2);
`ifdef SEQ_TIMEOUT_EN
        push(1, 14); push(2, 1);
`endif
        press();
        run_stage(0);
        wait_start(1);
`ifdef SEQ_TIMEOUT_EN
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (error === 1'b1) break;
            n++;
        end
        chk("wd_wait_cycles", 32'(n), 16);
        chk("err_flag", 32'(error), 1);
        chk("err_stage", 32'(err_stage), 1);
        chk("err_digit", 32'(output_digit), 14);
        chk("err_stage_reset", 32'(stg.stage_reset), 7);
        tick(1);
        push(1, 10);
        press();
        tick(2);
        chk("err_cleared", 32'(error), 0);
`else
        tick(40);
        chk("stall_busy", 32'(busy), 1);
        chk("stall_no_error", {30'd0, error, 1'b0}, 0);
        chk("stall_enable", 32'(stg.stage_enable), 2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(2);
`endif
        chk("idle_again", 32'(stg.stage_enable), 7);

        push(0, 1);
        press();
        wait_start(0);
        tick(1);
        en = 1'b0;
        stg.stage_done = 3'b001;
        tick(2);
        stg.stage_done = '0;
        tick(8);
        chk("frozen_busy", 32'(busy), 1);
        chk("frozen_enable", 32'(stg.stage_enable), 1);
        push(0, 2);
        en = 1'b1;
        stg.stage_done = 3'b001;
        tick(1);
        stg.stage_done = '0;
        chk("advance_start", 32'(stg.stage_start), 2);
        tick(1);
        reset = 1'b1;
        tick(1);
        chk("midrst_reset_display", 32'(reset_display), 1);
        chk("midrst_stage_reset", 32'(stg.stage_reset), 7);
        chk("midrst_busy", 32'(busy), 0);
        reset = 1'b0;
        tick(3);
        chk("scoreboard_drain", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
